ram_bridge_tx: RTL and testbench

RAM_BRIDGE_TX -- requirements
Module: ram_bridge_tx

---
 rtl/ram_bridge_tx.sv | 131 +++++++++++++
 tb/tb_ram_bridge_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bridge_tx.sv
// ram_bridge_tx: serialises one (address, data) word request into a byte packet.
// Packet: HEADER, addr bytes LSB first, data bytes LSB first, then the top data nibble.
// Optional macro RAM_BRIDGE_TX_CHECKSUM_EN appends an XOR checksum of the payload bytes.
module ram_bridge_tx #(
    parameter logic [7:0] HEADER = 8'h52
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] addr_in,
    input  logic [35:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  byte_out,
    output logic        byte_valid_out,
    input  logic        byte_ready_in,
    output logic        busy_out
);

`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t      state;
    state_t      next_state;
    logic [3:0]  index;
    logic [31:0] addr_q;
    logic [35:0] data_q;
    logic [7:0]  payload_byte;
    logic        accept;
    logic        xfer;
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign ready_out      = (state == IDLE) && rst_n_in;
    assign byte_valid_out = (state != IDLE);
    assign busy_out       = (state != IDLE);
    assign accept         = valid_in && ready_out;
    assign xfer           = byte_valid_out && byte_ready_in;

    // Select the payload byte addressed by the current index.
    always_comb begin
        payload_byte = 8'h00;
        case (index)
            4'd0:    payload_byte = addr_q[7:0];
            4'd1:    payload_byte = addr_q[15:8];
            4'd2:    payload_byte = addr_q[23:16];
            4'd3:    payload_byte = addr_q[31:24];
            4'd4:    payload_byte = data_q[7:0];
            4'd5:    payload_byte = data_q[15:8];
            4'd6:    payload_byte = data_q[23:16];
            4'd7:    payload_byte = data_q[31:24];
            4'd8:    payload_byte = {4'b0000, data_q[35:32]};
            default: payload_byte = 8'h00;
        endcase
    end

    // Next-state decode and the byte presented in each state.
    always_comb begin
        next_state = state;
        byte_out   = 8'h00;
        case (state)
            IDLE: begin
                if (accept) next_state = HDR;
            end
            HDR: begin
                byte_out = HEADER;
                if (byte_ready_in) next_state = PAY;
            end
            PAY: begin
                byte_out = payload_byte;
                if (byte_ready_in && (index == 4'd8)) begin
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
                    next_state = CSUM;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
            CSUM: begin
                byte_out = csum;
                if (byte_ready_in) next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= next_state;
    end

    // Capture the request and step the payload index as bytes are accepted.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q <= 32'h0;
            data_q <= 36'h0;
            index  <= 4'd0;
        end else begin
            if (accept) begin
                addr_q <= addr_in;
                data_q <= data_in;
            end
            if (state == HDR && xfer) begin
                index <= 4'd0;
            end else if (state == PAY && xfer) begin
                if (index == 4'd8) index <= 4'd0;
                else               index <= index + 4'd1;
            end
        end
    end

`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
    // Running XOR of payload bytes, cleared when a new request is taken.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            csum <= 8'h00;
        end else if (accept) begin
            csum <= 8'h00;
        end else if (state == PAY && xfer) begin
            csum <= csum ^ payload_byte;
        end
    end
`endif

endmodule

// File: tb/tb_ram_bridge_tx.sv
// tb_ram_bridge_tx: directed self-checking bench for ram_bridge_tx.
// Honours RAM_BRIDGE_TX_CHECKSUM_EN to expect the extra checksum byte.
module tb_ram_bridge_tx;

`ifdef RAM_BRIDGE_TX_CHECKSUM_EN
    localparam int PKT_LEN = 11;
`else
    localparam int PKT_LEN = 10;
`endif

    logic        pixel_clk_in;
    logic        rst_n_in;
    logic [31:0] addr_in;
    logic [35:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        byte_ready_in;
    logic        busy_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] pkt_a    [11];
    logic [7:0] pkt_b    [11];
    logic [7:0] pkt_zero [11];

    ram_bridge_tx #(.HEADER(8'h52)) dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_n_in       (rst_n_in),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .byte_out       (byte_out),
        .byte_valid_out (byte_valid_out),
        .byte_ready_in  (byte_ready_in),
        .busy_out       (busy_out)
    );

    // Free-running clock.
    initial pixel_clk_in = 1'b0;
    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [35:0] d);
        addr_in  = a;
        data_in  = d;
        valid_in = 1'b1;
        checkOutput({tag, " ready before accept"}, ready_out, 1);
        tick();
        valid_in = 1'b0;
        checkOutput({tag, " busy after accept"}, busy_out, 1);
    endtask

    task automatic recvPacket(input string tag, input logic [7:0] exp [11], input int n,
                              input bit throttle, input bit scramble);
        int   got;
        int   cyc;
        logic rdy;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            rdy = throttle ? ((cyc % 3) == 0) : 1'b1;
            byte_ready_in = rdy;
            if (scramble) begin
                addr_in = $urandom;
                data_in = {4'($urandom), 32'($urandom)};
            end
            checkOutput($sformatf("%s valid[%0d]", tag, got), byte_valid_out, 1);
            checkOutput($sformatf("%s byte[%0d]", tag, got), byte_out, exp[got]);
            checkOutput($sformatf("%s ready[%0d]", tag, got), ready_out, 0);
            if (rdy) got++;
            tick();
            cyc++;
        end
        if (got < n) checkOutput({tag, " timeout bytes"}, got, n);
        if (!throttle && n == PKT_LEN) checkOutput({tag, " cycles"}, cyc, n);
        byte_ready_in = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " ready"}, ready_out, 1);
        checkOutput({tag, " busy"}, busy_out, 0);
        checkOutput({tag, " valid"}, byte_valid_out, 0);
    endtask

    initial begin
        pkt_a    = '{8'h52, 8'h78, 8'h56, 8'h34, 8'h12, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h0A, 8'h82};
        pkt_b    = '{8'h52, 8'h01, 8'h00, 8'hFE, 8'hCA, 8'h44, 8'h33, 8'h22, 8'h11, 8'h05, 8'h74};
        pkt_zero = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst_n_in      = 1'b0;
        addr_in       = 32'h0;
        data_in       = 36'h0;
        valid_in      = 1'b0;
        byte_ready_in = 1'b1;

        // Reset state.
        tick();
        tick();
        checkOutput("reset ready", ready_out, 0);
        checkOutput("reset busy", busy_out, 0);
        checkOutput("reset valid", byte_valid_out, 0);
        checkOutput("reset byte", byte_out, 0);
        rst_n_in = 1'b1;
        #1;
        checkIdle("after release");

        // byte_ready_in in IDLE does nothing.
        tick();
        tick();
        checkIdle("idle with byte_ready");
        checkOutput("idle byte", byte_out, 0);

        // Single packet, full rate.
        applyStimulus("pktA", 32'h12345678, 36'hA_BCDE_F012);
        recvPacket("pktA", pkt_a, PKT_LEN, 1'b0, 1'b0);
        checkIdle("pktA done");

        // Throttled transmitter: 1,0,0 pattern.
        applyStimulus("thr", 32'h12345678, 36'hA_BCDE_F012);
        recvPacket("thr", pkt_a, PKT_LEN, 1'b1, 1'b0);
        checkIdle("thr done");

        // valid_in held high across two different words.
        addr_in  = 32'h12345678;
        data_in  = 36'hA_BCDE_F012;
        valid_in = 1'b1;
        tick();
        addr_in = 32'hCAFE0001;
        data_in = 36'h5_1122_3344;
        recvPacket("hold1", pkt_a, PKT_LEN, 1'b0, 1'b0);
        checkOutput("hold second ready", ready_out, 1);
        tick();
        valid_in = 1'b0;
        recvPacket("hold2", pkt_b, PKT_LEN, 1'b0, 1'b0);
        checkIdle("hold done");

        // Inputs scrambled during transmission must not leak into the packet.
        applyStimulus("scr", 32'hCAFE0001, 36'h5_1122_3344);
        recvPacket("scr", pkt_b, PKT_LEN, 1'b0, 1'b1);
        checkIdle("scr done");

        // Reset after the 4th byte abandons the packet.
        applyStimulus("rst", 32'h12345678, 36'hA_BCDE_F012);
        recvPacket("rst", pkt_a, 4, 1'b0, 1'b0);
        checkOutput("mid busy before reset", busy_out, 1);
        rst_n_in = 1'b0;
        #1;
        checkOutput("mid reset valid", byte_valid_out, 0);
        checkOutput("mid reset busy", busy_out, 0);
        checkOutput("mid reset ready", ready_out, 0);
        checkOutput("mid reset byte", byte_out, 0);
        tick();
        rst_n_in = 1'b1;
        #1;
        checkIdle("mid reset release");
        applyStimulus("zero", 32'h0, 36'h0);
        recvPacket("zero", pkt_zero, PKT_LEN, 1'b0, 1'b0);
        checkIdle("zero done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
